antares_bus_arbiter: RTL
========================

ANTARES_BUS_ARBITER -- requirements
Module: antares_bus_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, address width of all ports.
REQ-002 Parameter: DATA_WIDTH, 32, data width of all ports.
REQ-003 Parameter: TIMEOUT, 15, max cycles granted port waits for bus_ready; legal 1..255.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 m0_req / m1_req  input  1  requester n has a transaction pending; held until mn_ready or mn_error.
REQ-007 m0_addr / m1_addr  input  ADDR_WIDTH  requester address.
REQ-008 m0_wdata / m1_wdata  input  DATA_WIDTH  write data.
REQ-009 m0_wbe / m1_wbe  input  DATA_WIDTH/8  byte write enables; all-zero = read.
REQ-010 m0_ready / m1_ready  output  1  transaction complete, one-cycle pulse.
REQ-011 m0_error / m1_error  output  1  transaction timed out, one-cycle pulse.
REQ-012 mx_rdata  output  DATA_WIDTH  read data, shared, valid with mn_ready.
REQ-013 bus_addr / bus_wdata / bus_wbe  output  per above  muxed request to shared bus.
REQ-014 bus_valid  output  1  shared-bus request strobe.
REQ-015 bus_ready  input  1  shared-bus completion.
REQ-016 bus_rdata  input  DATA_WIDTH  shared-bus read data.
REQ-017 grant_sel  output  1  current owner (0 = m0, 1 = m1); drives select of the 2:1 request mux.

Function
REQ-018 FSM states IDLE, GRANT0, GRANT1; state register only changes on clk edge.
REQ-019 IDLE: bus_valid=0; if one req asserted, next state GRANTn for that requester.
REQ-020 IDLE, both req asserted: grant the requester not served last (round-robin); last_served resets to 1, so m0 wins first tie.
REQ-021 GRANTn: bus_valid=1, grant_sel=n, bus_addr/wdata/wbe = mn fields combinationally.
REQ-022 GRANTn with bus_ready=1: mn_ready=1 same cycle, mx_rdata=bus_rdata, last_served<=n.
REQ-023 On completion, if other requester's req=1, next state GRANT(other) (zero-bubble handoff); else IDLE.
REQ-024 A requester completed this cycle is not re-granted next cycle if the other is pending; if other idle, next state IDLE (one bubble before same requester again).
REQ-025 Wait counter cleared on entry to GRANTn, increments each GRANTn cycle without bus_ready.
REQ-026 Counter reaching TIMEOUT without bus_ready: mn_error=1 for one cycle, bus_valid=0 next cycle, transition per REQ-023 rules, last_served<=n.
REQ-027 bus_ready on the timeout cycle: treated as completion (ready, not error).
REQ-028 mn_ready and mn_error never both asserted; non-granted port's ready/error always 0.
REQ-029 req deassert while granted is a protocol violation; arbiter keeps grant until bus_ready or timeout.
REQ-030 grant_sel holds last value in IDLE; mx_rdata = bus_rdata at all times.

Reset
REQ-031 rst=1 at any clk edge: state<=IDLE, last_served<=1, counter<=0, grant_sel<=0, next cycle bus_valid=0, all ready/error=0.
REQ-032 Reset mid-transaction abandons it silently; no ready/error pulse issued.

Structure
REQ-033 FSM state encodings and default TIMEOUT constant in shared antares_defines package/header.
REQ-034 Request datapath instantiates antares_mux_2_1 (WIDTH=ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8) driven by grant_sel; no other sub-module.

Verification
REQ-035 Only m0_req, bus_ready after 2 cycles -> GRANT0 one cycle after req, m0_ready pulse on 3rd GRANT0 cycle, IDLE next.
REQ-036 m0_req and m1_req same cycle after reset, bus_ready immediate -> m0 served, then GRANT1 next cycle with no IDLE bubble.
REQ-037 Both held continuously, bus_ready always 1 -> grants alternate 0,1,0,1; each port one ready per 2 cycles.
REQ-038 m1_req, bus_ready never -> m1_error after 15 GRANT1 cycles, bus_valid 0 next cycle, m1_ready never.
REQ-039 rst asserted during GRANT1 wait -> IDLE next cycle, bus_valid 0, no ready/error; subsequent m1_req served normally.
REQ-040 Write from m1 (wbe=4'hF, addr 32'h100, wdata 32'hDEADBEEF) -> bus_addr/wdata/wbe match exactly while grant_sel=1.

Source files
------------

// File: rtl/antares_defines.sv
// Shared definitions for the antares bus arbiter: FSM encodings, the default
// wait timeout and a helper mapping a requester index to its grant state.
package antares_defines;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT = 15;

    function automatic arb_state_e grant_state(input logic sel);
        return sel ? ST_GRANT1 : ST_GRANT0;
    endfunction

endpackage

// File: rtl/antares_mux_2_1.sv
// Generic 2:1 multiplexer used to steer the owning requester onto the shared bus.
module antares_mux_2_1 #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/antares_bus_arbiter.sv
// Two-requester round-robin arbiter for a shared bus, with a per-grant wait
// timeout that turns an unanswered request into an error pulse.
module antares_bus_arbiter
    import antares_defines::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wbe,
    output logic                    m0_ready,
    output logic                    m0_error,
    input  logic                    m1_req,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wbe,
    output logic                    m1_ready,
    output logic                    m1_error,
    output logic [DATA_WIDTH-1:0]   mx_rdata,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_wbe,
    output logic                    bus_valid,
    input  logic                    bus_ready,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic                    grant_sel
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int REQ_WIDTH = ADDR_WIDTH + DATA_WIDTH + BE_WIDTH;

    arb_state_e state_q, state_d;
    logic       last_served_q, last_served_d;
    logic       grant_sel_q, grant_sel_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic granted, owner, done, timed_out, other_req;

    assign granted   = (state_q != ST_IDLE);
    assign owner     = (state_q == ST_GRANT1);
    assign done      = granted && bus_ready;
    assign timed_out = granted && !bus_ready && (wait_cnt_q == 8'(TIMEOUT - 1));
    assign other_req = owner ? m0_req : m1_req;

    // A grant ends on completion or timeout; the other side is served next if
    // it is waiting, otherwise we bubble through IDLE before re-arbitrating.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        grant_sel_d   = grant_sel_q;
        wait_cnt_d    = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    grant_sel_d = (m0_req && m1_req) ? ~last_served_q : m1_req;
                    state_d     = grant_state(grant_sel_d);
                    wait_cnt_d  = 8'd0;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (done || timed_out) begin
                    last_served_d = owner;
                    if (other_req) begin
                        grant_sel_d = ~owner;
                        state_d     = grant_state(~owner);
                        wait_cnt_d  = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_served_q <= 1'b1;
            grant_sel_q   <= 1'b0;
            wait_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            grant_sel_q   <= grant_sel_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Completion pulses are suppressed while reset abandons a transaction.
    assign m0_ready  = done && !owner && !rst;
    assign m1_ready  = done &&  owner && !rst;
    assign m0_error  = timed_out && !owner && !rst;
    assign m1_error  = timed_out &&  owner && !rst;
    assign bus_valid = granted;
    assign grant_sel = grant_sel_q;
    assign mx_rdata  = bus_rdata;

    antares_mux_2_1 #(
        .WIDTH(REQ_WIDTH)
    ) u_req_mux (
        .sel(grant_sel_q),
        .in0({m0_addr, m0_wdata, m0_wbe}),
        .in1({m1_addr, m1_wdata, m1_wbe}),
        .out({bus_addr, bus_wdata, bus_wbe})
    );

endmodule
